iot_event_arbiter: RTL and testbench
====================================

// Module: iot_event_arbiter
// PURPOSE
//  Front-end for the active-IoT-device monitor. Watches N_DEV asynchronous device
//  status lines, turns each connect or disconnect edge into a per-device pending event,
//  and serialises the events round-robin into one change/on_off pulse per clk. Its
//  outputs drive the monitor counter's change/on_off inputs directly.
// PARAMETERS
//  N_DEV        8  number of device status lines (2..32)
//  SYNC_STAGES  2  synchroniser flops per status line (>=2)
//  ID_W         $clog2(N_DEV)  width of dev_id (localparam)
// PORTS
//  clk          in   1       clock, rising edge
//  rst          in   1       reset, asynchronous, active-high
//  dev_status   in   N_DEV   1=device on, asynchronous level per device
//  stall        in   1       1=hold; no event issued this cycle
//  change       out  1       1-cycle pulse: one event issued
//  on_off       out  1       direction of issued event: 1=connect, 0=disconnect
//  dev_id       out  ID_W    index of device whose event is issued
//  busy         out  1       1 while any device has a pending event (|pending)
// BEHAVIOUR
//  Reset: all sync flops, prev[], pending[], dir[], change, on_off, dev_id -> 0.
//   rr_ptr -> N_DEV-1, so dev0 has first priority.
//   prev resets to 0, so devices already high at reset release each emit one connect
//   event. This brings a freshly reset monitor to the true count.
//  Synchroniser: SYNC_STAGES-flop chain per line; s[i] = last stage output.
//  Edge detect: edge[i] = s[i] ^ prev[i]; prev[i] <= s[i] every cycle.
//  Pending update per device i, each cycle, in priority order:
//   1. granted & edge: pending<=1, dir<=s[i]. Old event issued, new event queued.
//   2. granted & !edge: pending<=0.
//   3. !granted & edge & pending: pending<=0. Opposite edges cancel; net change is zero.
//   4. !granted & edge & !pending: pending<=1, dir<=s[i].
//   5. otherwise: hold.
//  Arbiter:
//   - Inputs: pending[] as registered at start of cycle.
//   - If stall=0 and any pending: grant the first pending index searching rr_ptr+1
//     upward, wrapping modulo N_DEV. rr_ptr <= granted index.
//   - If stall=1 or none pending: no grant; rr_ptr holds.
//  Outputs are registered:
//   - Grant: change<=1, on_off<=dir[g], dev_id<=g on the next edge.
//   - No grant: change<=0. on_off and dev_id hold their last values.
//  Latency (uncontended, stall=0): dev_status edge -> change=1 exactly SYNC_STAGES+2
//   rising clk edges later. With the default this is 4.
//  Throughput: at most 1 event/cycle. N simultaneous edges drain in N consecutive cycles.
//  Loss rules:
//   - Status pulses shorter than 1 clk period may be missed. This is permitted.
//   - At most one event per device is pending at any time. A same-direction duplicate
//     is impossible because edges alternate.
//  Timing:
//   - stall is sampled synchronously.
//   - stall asserted while change=1 does not retract the pulse already on the outputs.
//  Reset mid-operation: outputs drop to 0 immediately (async). All pending events are
//   discarded; devices still high re-announce as connects after release.
// TESTING
//  T1 dev_status=8'h05 held through rst; release -> change pulses on 2 consecutive
//     cycles: (dev_id=0,on_off=1) then (dev_id=2,on_off=1); busy=0 afterwards.
//  T2 from idle, dev3 0->1 -> change=1,on_off=1,dev_id=3 exactly 4 clks later; after
//     20 clks dev3 1->0 -> change=1,on_off=0,dev_id=3 4 clks later.
//  T3 all 8 lines 0->1 in one cycle with rr_ptr=7 -> 8 back-to-back pulses,
//     dev_id 0,1,...,7, all on_off=1; a driven monitor counter reads 8.
//  T4 stall=1; dev5 0->1, 3 clks later 1->0; release stall -> no change pulse,
//     busy=0 throughout final 5 clks.
//  T5 dev1,dev6 pending, stall=1 for 10 clks -> change=0, busy=1; stall=0 ->
//     dev_id=1 then dev_id=6 on consecutive cycles.
//  T6 rst asserted mid-drain of T3 after 3 pulses -> change,on_off,dev_id=0 at once;
//     release with all lines high -> 8 fresh connect pulses.

Source files
------------

// File: rtl/iot_event_arbiter_if.sv
// Event bus between the device status lines, the arbiter and the monitor counter.
// master: the side that drives status/stall and consumes issued events.
// slave:  the arbiter itself.
interface iot_event_arbiter_if #(
  parameter int N_DEV = 8
);
  localparam int ID_W = (N_DEV > 1) ? $clog2(N_DEV) : 1;

  logic [N_DEV-1:0] dev_status;
  logic             stall;
  logic             change;
  logic             on_off;
  logic [ID_W-1:0]  dev_id;
  logic             busy;

  modport master (
    output dev_status, stall,
    input  change, on_off, dev_id, busy
  );

  modport slave (
    input  dev_status, stall,
    output change, on_off, dev_id, busy
  );
endinterface

// File: rtl/iot_event_arbiter.sv
// Synchronises N_DEV asynchronous device status lines, converts each edge into a
// per-device pending connect/disconnect event, and issues at most one event per
// clock in round-robin order as a registered change/on_off/dev_id pulse.
module iot_event_arbiter #(
  parameter int N_DEV       = 8,
  parameter int SYNC_STAGES = 2
) (
  input logic               clk,
  input logic               rst,
  iot_event_arbiter_if.slave bus
);
  localparam int ID_W = (N_DEV > 1) ? $clog2(N_DEV) : 1;

  logic [N_DEV-1:0] sync_reg [SYNC_STAGES];
  logic [N_DEV-1:0] sync_out;
  logic [N_DEV-1:0] prev_reg;
  logic [N_DEV-1:0] pending_reg;
  logic [N_DEV-1:0] pending_next;
  logic [N_DEV-1:0] dir_reg;
  logic [N_DEV-1:0] dir_next;
  logic [N_DEV-1:0] edge_w;
  logic [N_DEV-1:0] granted;
  logic [ID_W-1:0]  rr_ptr_reg;
  logic [ID_W-1:0]  grant_idx;
  logic [ID_W-1:0]  cand;
  logic             grant_valid;
  logic             change_reg;
  logic             on_off_reg;
  logic [ID_W-1:0]  dev_id_reg;

  // Synchroniser chain per status line; last stage is the clean level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_reg[k] <= '0;
    end else begin
      sync_reg[0] <= bus.dev_status;
      for (int k = 1; k < SYNC_STAGES; k++) sync_reg[k] <= sync_reg[k-1];
    end
  end

  assign sync_out = sync_reg[SYNC_STAGES-1];

  // Per-device edge detection and pending/direction bookkeeping.
  // A granted device keeps a pending event only if a new edge arrives in the same
  // cycle; an ungranted device toggles pending on an edge, so opposite edges cancel.
  genvar gi;
  generate
    for (gi = 0; gi < N_DEV; gi++) begin : g_dev
      assign edge_w[gi]       = sync_out[gi] ^ prev_reg[gi];
      assign granted[gi]      = grant_valid && (grant_idx == ID_W'(gi));
      assign pending_next[gi] = granted[gi] ? edge_w[gi]
                              : (edge_w[gi] ? ~pending_reg[gi] : pending_reg[gi]);
      assign dir_next[gi]     = (edge_w[gi] && (granted[gi] || !pending_reg[gi]))
                              ? sync_out[gi] : dir_reg[gi];
    end
  endgenerate

  // Round-robin search starting just after the last granted index.
  // Walking the offsets downward lets the nearest pending device win.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    if (!bus.stall) begin
      for (int k = N_DEV; k >= 1; k--) begin
        cand = ID_W'((int'(rr_ptr_reg) + k) % N_DEV);
        if (pending_reg[cand]) begin
          grant_valid = 1'b1;
          grant_idx   = cand;
        end
      end
    end
  end

  // Event state registers; prev starts at 0 so lines high at release announce themselves.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_reg    <= '0;
      pending_reg <= '0;
      dir_reg     <= '0;
    end else begin
      prev_reg    <= sync_out;
      pending_reg <= pending_next;
      dir_reg     <= dir_next;
    end
  end

  // Registered event outputs and round-robin pointer; on_off/dev_id hold between grants.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      change_reg <= 1'b0;
      on_off_reg <= 1'b0;
      dev_id_reg <= '0;
      rr_ptr_reg <= ID_W'(N_DEV - 1);
    end else if (grant_valid) begin
      change_reg <= 1'b1;
      on_off_reg <= dir_reg[grant_idx];
      dev_id_reg <= grant_idx;
      rr_ptr_reg <= grant_idx;
    end else begin
      change_reg <= 1'b0;
    end
  end

  assign bus.change = change_reg;
  assign bus.on_off = on_off_reg;
  assign bus.dev_id = dev_id_reg;
  assign bus.busy   = |pending_reg;
endmodule

// File: tb/tb_iot_event_arbiter.sv
// Bench for iot_event_arbiter: directed scenarios plus randomized traffic, all
// outputs compared every cycle against an event-level reference model.
module tb_iot_event_arbiter;
  localparam int N = 8;
  localparam int S = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  iot_event_arbiter_if #(.N_DEV(N)) bus();

  iot_event_arbiter #(.N_DEV(N), .SYNC_STAGES(S)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks  = 0;
  int errors  = 0;
  int monitor = 0;

  // Reference model: the status seen S edges ago is the settled level; each device
  // holds at most one outstanding event with a direction.
  logic [N-1:0] m_hist [S];
  logic [N-1:0] m_prev;
  logic [N-1:0] m_pend;
  logic [N-1:0] m_dir;
  int           m_rr;
  logic         m_change;
  logic         m_on_off;
  int           m_id;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < S; k++) m_hist[k] = '0;
    m_prev   = '0;
    m_pend   = '0;
    m_dir    = '0;
    m_rr     = N - 1;
    m_change = 1'b0;
    m_on_off = 1'b0;
    m_id     = 0;
  endtask

  task automatic model_step();
    logic [N-1:0] lvl;
    logic [N-1:0] ed;
    logic [N-1:0] gm;
    int g;
    lvl = m_hist[S-1];
    ed  = lvl ^ m_prev;
    g   = -1;
    if (!bus.stall) begin
      for (int k = 1; k <= N; k++) begin
        if (g < 0 && m_pend[(m_rr + k) % N]) g = (m_rr + k) % N;
      end
    end
    gm = '0;
    if (g >= 0) begin
      m_change = 1'b1;
      m_on_off = m_dir[g];
      m_id     = g;
      m_rr     = g;
      gm[g]    = 1'b1;
    end else begin
      m_change = 1'b0;
    end
    m_dir  = (m_dir & ~ed) | (lvl & ed);
    m_pend = (m_pend & ~gm) ^ ed;
    m_prev = lvl;
    for (int k = S - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
    m_hist[0] = bus.dev_status;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else     model_step();
    #1;
    chk("model_change", 32'(bus.change), 32'(m_change));
    chk("model_on_off", 32'(bus.on_off), 32'(m_on_off));
    chk("model_dev_id", 32'(bus.dev_id), 32'(m_id));
    chk("model_busy",   32'(bus.busy),   32'(|m_pend));
    if (bus.change === 1'b1) monitor += (bus.on_off ? 1 : -1);
  endtask

  task automatic do_reset(input logic [N-1:0] lines);
    rst = 1'b1;
    bus.dev_status = lines;
    tick();
    tick();
    rst = 1'b0;
  endtask

  logic [N-1:0] cur;

  initial begin
    bus.dev_status = 8'h05;
    bus.stall      = 1'b0;
    model_reset();
    repeat (3) tick();
    chk("rst_change", 32'(bus.change), 32'd0);
    chk("rst_on_off", 32'(bus.on_off), 32'd0);
    chk("rst_dev_id", 32'(bus.dev_id), 32'd0);
    chk("rst_busy",   32'(bus.busy),   32'd0);
    rst = 1'b0;

    // T1: lines high through reset announce as connects, dev0 first
    repeat (3) tick();
    chk("t1_quiet", 32'(bus.change), 32'd0);
    tick();
    chk("t1_p0_change", 32'(bus.change), 32'd1);
    chk("t1_p0_id",     32'(bus.dev_id), 32'd0);
    chk("t1_p0_on",     32'(bus.on_off), 32'd1);
    tick();
    chk("t1_p1_change", 32'(bus.change), 32'd1);
    chk("t1_p1_id",     32'(bus.dev_id), 32'd2);
    chk("t1_p1_on",     32'(bus.on_off), 32'd1);
    tick();
    chk("t1_end_change", 32'(bus.change), 32'd0);
    chk("t1_end_busy",   32'(bus.busy),   32'd0);

    // T2: single connect then disconnect, latency 4 edges
    bus.dev_status = 8'h0D;
    repeat (3) tick();
    chk("t2_early", 32'(bus.change), 32'd0);
    tick();
    chk("t2_on_change", 32'(bus.change), 32'd1);
    chk("t2_on_id",     32'(bus.dev_id), 32'd3);
    chk("t2_on_dir",    32'(bus.on_off), 32'd1);
    repeat (16) tick();
    bus.dev_status = 8'h05;
    repeat (3) tick();
    chk("t2_off_early", 32'(bus.change), 32'd0);
    tick();
    chk("t2_off_change", 32'(bus.change), 32'd1);
    chk("t2_off_id",     32'(bus.dev_id), 32'd3);
    chk("t2_off_dir",    32'(bus.on_off), 32'd0);

    // T3: all lines rise together, drain 0..7 back to back
    do_reset(8'h00);
    repeat (2) tick();
    monitor = 0;
    bus.dev_status = 8'hFF;
    repeat (3) tick();
    for (int k = 0; k < N; k++) begin
      tick();
      chk("t3_change", 32'(bus.change), 32'd1);
      chk("t3_id",     32'(bus.dev_id), 32'(k));
      chk("t3_on",     32'(bus.on_off), 32'd1);
    end
    tick();
    chk("t3_count", 32'(monitor), 32'd8);
    chk("t3_busy",  32'(bus.busy), 32'd0);

    // T6: reset in the middle of a drain, then lines re-announce
    do_reset(8'h00);
    repeat (2) tick();
    bus.dev_status = 8'hFF;
    repeat (6) tick();
    chk("t6_pre_id", 32'(bus.dev_id), 32'd2);
    rst = 1'b1;
    #1;
    chk("t6_async_change", 32'(bus.change), 32'd0);
    chk("t6_async_on_off", 32'(bus.on_off), 32'd0);
    chk("t6_async_dev_id", 32'(bus.dev_id), 32'd0);
    chk("t6_async_busy",   32'(bus.busy),   32'd0);
    tick();
    tick();
    rst = 1'b0;
    monitor = 0;
    repeat (3) tick();
    for (int k = 0; k < N; k++) begin
      tick();
      chk("t6_change", 32'(bus.change), 32'd1);
      chk("t6_id",     32'(bus.dev_id), 32'(k));
      chk("t6_on",     32'(bus.on_off), 32'd1);
    end
    chk("t6_count", 32'(monitor), 32'd8);

    // T4: connect then disconnect under stall cancel each other
    do_reset(8'h00);
    repeat (2) tick();
    bus.stall = 1'b1;
    bus.dev_status = 8'h20;
    repeat (3) tick();
    bus.dev_status = 8'h00;
    repeat (5) tick();
    bus.stall = 1'b0;
    repeat (5) begin
      tick();
      chk("t4_change", 32'(bus.change), 32'd0);
      chk("t4_busy",   32'(bus.busy),   32'd0);
    end

    // T5: two pending events held by stall, then released in order
    bus.stall = 1'b1;
    bus.dev_status = 8'h42;
    repeat (10) tick();
    chk("t5_stall_change", 32'(bus.change), 32'd0);
    chk("t5_stall_busy",   32'(bus.busy),   32'd1);
    bus.stall = 1'b0;
    tick();
    chk("t5_first_change", 32'(bus.change), 32'd1);
    chk("t5_first_id",     32'(bus.dev_id), 32'd1);
    tick();
    chk("t5_second_change", 32'(bus.change), 32'd1);
    chk("t5_second_id",     32'(bus.dev_id), 32'd6);
    tick();
    chk("t5_busy_end", 32'(bus.busy), 32'd0);

    // Randomized toggles and stalls, checked cycle by cycle against the model
    cur = bus.dev_status;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 2) == 0) cur ^= 8'(1 << $urandom_range(0, N - 1));
      bus.dev_status = cur;
      bus.stall = ($urandom_range(0, 3) == 0);
      if (n == 250) begin
        rst = 1'b1;
        #1;
        chk("rnd_async_change", 32'(bus.change), 32'd0);
        tick();
        rst = 1'b0;
      end
      tick();
    end
    bus.stall = 1'b0;
    repeat (N + 6) tick();
    chk("rnd_drained", 32'(bus.busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
